// File: rtl/icache_decomp_fill_pkg.sv
// Shared types and constants for the compressed instruction fill unit.
package icache_decomp_pkg;

    // Fill sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        LAT,
        FETCH,
        DECODE,
        RESP
    } state_t;

    // Progress through a three-halfword literal code.
    typedef enum logic [1:0] {
        LIT_NONE,
        LIT_LO,
        LIT_HI
    } lit_phase_t;

    // Code halfword that introduces a literal; the next two halfwords carry the instruction.
    localparam logic [15:0] LIT_MARK  = 16'h0000;
    // Bit that marks a dictionary reference.
    localparam int          DICT_FLAG = 15;

    // Cache line number of a byte address; lb is log2 of the line size in bytes.
    function automatic logic [31:0] addr_line(input logic [31:0] addr, input int lb);
        return addr >> lb;
    endfunction

    // Word slot within the line for a byte address.
    function automatic logic [31:0] addr_slot(input logic [31:0] addr, input int lb);
        return (addr & ((32'd1 << lb) - 32'd1)) >> 2;
    endfunction

endpackage

// File: rtl/icache_decomp_fill_if.sv
// Cache miss-port request bus plus compressed-memory read bus.
interface icache_decomp_fill_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_rdata;
    logic        cmem_valid;
    logic        cmem_ready;
    logic [31:0] cmem_addr;
    logic [31:0] cmem_rdata;

    // Environment side: the instruction cache and the compressed memory.
    modport master (
        output req_valid, req_addr, cmem_ready, cmem_rdata,
        input  req_ready, req_rdata, cmem_valid, cmem_addr
    );

    // Fill unit side.
    modport slave (
        input  req_valid, req_addr, cmem_ready, cmem_rdata,
        output req_ready, req_rdata, cmem_valid, cmem_addr
    );
endinterface

// File: rtl/icache_decomp_fill_hw_stream_unpack.sv
// Two-halfword holding register that hands out fetched code halfwords one at a time,
// lower halfword first.
module hw_stream_unpack (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        skip_low,
    input  logic        pop,
    output logic        empty,
    output logic [15:0] hw
);

    logic [31:0] hold_q;
    logic [1:0]  count_q;

    // Load a fetched word, or retire one halfword per pop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            hold_q  <= '0;
            count_q <= '0;
        end else if (load) begin
            hold_q  <= load_word;
            count_q <= skip_low ? 2'd1 : 2'd2;
        end else if (pop && count_q != 2'd0) begin
            count_q <= count_q - 2'd1;
        end
    end

    // Two halfwords left means the low one is next; one left means the high one.
    assign empty = (count_q == 2'd0);
    assign hw    = (count_q == 2'd2) ? hold_q[15:0] : hold_q[31:16];

endmodule

// File: rtl/icache_decomp_fill.sv
// Instruction-cache fill unit that expands a dictionary/literal compressed image
// into a one-line buffer and answers word requests from it.
module icache_decomp_fill
    import icache_decomp_pkg::*;
#(
    parameter int          NUM_BLOCKS   = 4,
    parameter int          BLOCK_SIZE   = 4,
    parameter int          DICT_ENTRIES = 256,
    parameter logic [31:0] LAT_BASE     = 32'h0008_0000
) (
    input  logic                clk,
    input  logic                resetn,
    icache_decomp_fill_if.slave bus,
    output logic                dbg_fill,
    output logic                dbg_code_err
);

    localparam int LB   = $clog2(NUM_BLOCKS * BLOCK_SIZE);
    localparam int DAW  = $clog2(DICT_ENTRIES);
    localparam int WC_W = $clog2(NUM_BLOCKS + 1);

    // Read-only dictionary; its contents are loaded from outside before use.
    logic [31:0] dict [DICT_ENTRIES];

    state_t          state_q, state_d;
    logic [31:0]     line_q, slot_q, tag_q;
    logic            buf_valid_q;
    logic [31:0]     line_buf [NUM_BLOCKS];
    logic [29:0]     ptr_word_q;
    logic            ptr_skip_q;
    logic [WC_W-1:0] wcnt_q;
    lit_phase_t      lit_q;
    logic [15:0]     lit_lo_q;
    logic            gap_q;

    logic [31:0] cur_line, cur_slot;
    logic        hit, accept;
    logic        unpack_load, unpack_pop, unpack_empty;
    logic [15:0] hw;
    logic        dec_write, dec_err, last_write;
    logic [31:0] dec_word;

    assign cur_line = addr_line(bus.req_addr, LB);
    assign cur_slot = addr_slot(bus.req_addr, LB);
    assign hit      = buf_valid_q && (tag_q == cur_line);
    assign accept   = bus.cmem_valid && bus.cmem_ready;

    assign unpack_load = (state_q == FETCH) && accept;
    assign unpack_pop  = (state_q == DECODE) && !unpack_empty;

    hw_stream_unpack u_unpack (
        .clk       (clk),
        .resetn    (resetn),
        .load      (unpack_load),
        .load_word (bus.cmem_rdata),
        .skip_low  (ptr_skip_q),
        .pop       (unpack_pop),
        .empty     (unpack_empty),
        .hw        (hw)
    );

    // Interpret the current halfword according to where we are in a code.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        dec_write = 1'b0;
        dec_err   = 1'b0;
        dec_word  = '0;
        if (unpack_pop) begin
            case (lit_q)
                LIT_NONE: begin
                    if (hw[DICT_FLAG]) begin
                        dec_write = 1'b1;
                        dec_word  = dict[hw[DAW-1:0]];
                    end else if (hw != LIT_MARK) begin
                        dec_write = 1'b1;
                        dec_err   = 1'b1;
                    end
                end
                LIT_HI: begin
                    dec_write = 1'b1;
                    dec_word  = {hw, lit_lo_q};
                end
                default: ;
            endcase
        end
    end

    assign last_write = dec_write && (wcnt_q == WC_W'(NUM_BLOCKS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (bus.req_valid) state_d = hit ? RESP : LAT;
            LAT:    if (accept) state_d = FETCH;
            FETCH:  if (accept) state_d = DECODE;
            DECODE: begin
                if (unpack_empty)    state_d = FETCH;
                else if (last_write) state_d = bus.req_valid ? RESP : IDLE;
            end
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs decoded from the state; gap_q forces the idle cycle after each handshake.
    always_comb begin
        bus.cmem_valid = 1'b0;
        bus.cmem_addr  = '0;
        bus.req_ready  = 1'b0;
        bus.req_rdata  = '0;
        case (state_q)
            LAT: begin
                bus.cmem_valid = !gap_q;
                bus.cmem_addr  = LAT_BASE + (line_q << 2);
            end
            FETCH: begin
                bus.cmem_valid = !gap_q;
                bus.cmem_addr  = {ptr_word_q, 2'b00};
            end
            RESP: begin
                bus.req_ready = 1'b1;
                for (int i = 0; i < NUM_BLOCKS; i++) begin
                    if (slot_q == 32'(i)) bus.req_rdata = line_buf[i];
                end
            end
            default: ;
        endcase
    end

    // Request capture, LAT pointer, literal tracking, buffer tag and debug flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            line_q       <= '0;
            slot_q       <= '0;
            tag_q        <= '0;
            buf_valid_q  <= 1'b0;
            ptr_word_q   <= '0;
            ptr_skip_q   <= 1'b0;
            wcnt_q       <= '0;
            lit_q        <= LIT_NONE;
            lit_lo_q     <= '0;
            gap_q        <= 1'b0;
            dbg_fill     <= 1'b0;
            dbg_code_err <= 1'b0;
        end else begin
            gap_q    <= accept;
            dbg_fill <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        line_q <= cur_line;
                        slot_q <= cur_slot;
                        if (!hit) begin
                            buf_valid_q <= 1'b0;
                            wcnt_q      <= '0;
                            lit_q       <= LIT_NONE;
                        end
                    end
                end
                LAT: begin
                    if (accept) begin
                        ptr_word_q <= bus.cmem_rdata[31:2];
                        ptr_skip_q <= bus.cmem_rdata[1];
                    end
                end
                FETCH: begin
                    if (accept) begin
                        ptr_word_q <= ptr_word_q + 30'd1;
                        ptr_skip_q <= 1'b0;
                    end
                end
                DECODE: begin
                    if (unpack_pop) begin
                        case (lit_q)
                            LIT_NONE: if (hw == LIT_MARK) lit_q <= LIT_LO;
                            LIT_LO: begin
                                lit_lo_q <= hw;
                                lit_q    <= LIT_HI;
                            end
                            default: lit_q <= LIT_NONE;
                        endcase
                        if (dec_write) wcnt_q <= wcnt_q + WC_W'(1);
                        if (dec_err) dbg_code_err <= 1'b1;
                        if (last_write) begin
                            buf_valid_q <= 1'b1;
                            tag_q       <= line_q;
                            dbg_fill    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line buffer storage; decoded instructions land in consecutive slots.
    always_ff @(posedge clk) begin
        // NOTE: buffer data is not reset; buf_valid_q alone decides whether it may be read.
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (dec_write && wcnt_q == WC_W'(i)) line_buf[i] <= dec_word;
        end
    end

endmodule

// File: tb/tb_icache_decomp_fill.sv
// Self-checking bench: directed table, multi-cycle corner sequences, and a randomized
// phase scored against a stream-level decode model.
module tb_icache_decomp_fill;
    import icache_decomp_pkg::*;

    localparam logic [31:0] LAT_BASE = 32'h0008_0000;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic dbg_fill, dbg_code_err;

    icache_decomp_fill_if bus ();

    icache_decomp_fill #(
        .NUM_BLOCKS   (4),
        .BLOCK_SIZE   (4),
        .DICT_ENTRIES (256),
        .LAT_BASE     (LAT_BASE)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .dbg_fill     (dbg_fill),
        .dbg_code_err (dbg_code_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [bit [31:0]];
    logic [31:0] dict_m [256];

    int          mem_delay  = 0;
    int          txn_count  = 0;
    int          fill_count = 0;
    int          wait_cnt   = 0;
    int          stab_viol  = 0;
    bit          pending    = 0;
    logic [31:0] held_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = rd({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic put_hw(input logic [31:0] a, input logic [15:0] h);
        logic [31:0] w;
        w = rd({a[31:2], 2'b00});
        if (a[1]) w[31:16] = h;
        else      w[15:0]  = h;
        mem[{a[31:2], 2'b00}] = w;
    endtask

    // Compressed memory: answers after mem_delay waiting cycles, watches request stability.
    always @(negedge clk) begin
        if (!resetn) begin
            bus.cmem_ready = 1'b0;
            bus.cmem_rdata = '0;
            pending        = 0;
        end else if (bus.cmem_ready) begin
            bus.cmem_ready = 1'b0;
            pending        = 0;
        end else if (bus.cmem_valid) begin
            if (pending && bus.cmem_addr !== held_addr) stab_viol++;
            if (!pending) begin
                pending   = 1;
                held_addr = bus.cmem_addr;
                wait_cnt  = 0;
            end
            if (wait_cnt >= mem_delay) begin
                bus.cmem_ready = 1'b1;
                bus.cmem_rdata = rd(bus.cmem_addr);
                txn_count++;
            end else begin
                wait_cnt++;
            end
        end else begin
            if (pending) stab_viol++;
            pending = 0;
        end
    end

    always @(negedge clk) if (dbg_fill === 1'b1) fill_count++;

    // Reference decode of one line straight from the memory image.
    logic [31:0] m_words [4];
    bit          m_err_line;
    int          m_fetches;

    task automatic model_line(input logic [31:0] line);
        logic [31:0] ptr, a;
        logic [15:0] h, lo, hi;
        ptr        = rd(LAT_BASE + (line << 2));
        a          = {ptr[31:1], 1'b0};
        m_err_line = 0;
        for (int n = 0; n < 4; n++) begin
            h = hw_at(a);
            a = a + 2;
            if (h[15]) begin
                m_words[n] = dict_m[h[7:0]];
            end else if (h == 16'h0000) begin
                lo = hw_at(a);
                hi = hw_at(a + 2);
                a  = a + 4;
                m_words[n] = {hi, lo};
            end else begin
                m_words[n] = 32'h0;
                m_err_line = 1;
            end
        end
        m_fetches = int'(((a - 2) >> 2) - (ptr >> 2)) + 1;
    endtask

    // Random compressed line: junk-filled region, random start, mixed code kinds.
    task automatic gen_line(input logic [31:0] line);
        logic [31:0] base, ptr, a;
        int          kind;
        base = 32'h0001_0000 + line * 32'h100;
        for (int w = 0; w < 32; w++) mem[base + 4 * w] = $urandom;
        ptr = base + 32'($urandom_range(0, 1) * 2) + 32'($urandom_range(0, 1));
        mem[LAT_BASE + (line << 2)] = ptr;
        a = {ptr[31:1], 1'b0};
        for (int n = 0; n < 4; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                put_hw(a, 16'h8000 | 16'($urandom_range(0, 32767)));
                a = a + 2;
            end else if (kind <= 8) begin
                put_hw(a, 16'h0000);
                put_hw(a + 2, 16'($urandom));
                put_hw(a + 4, 16'($urandom));
                a = a + 6;
            end else begin
                put_hw(a, 16'($urandom_range(1, 32767)));
                a = a + 2;
            end
        end
    endtask

    // One request/response; counts memory transactions and fill pulses it caused.
    task automatic do_req(input logic [31:0] addr, output logic [31:0] rdata,
                          output int cycles, output int txns, output int fills);
        int t0, f0;
        bit got;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        t0     = txn_count;
        f0     = fill_count;
        cycles = 0;
        got    = 0;
        rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.req_ready) begin
                got   = 1;
                rdata = bus.req_rdata;
            end
        end
        bus.req_valid = 1'b0;
        check($sformatf("req_done_%h", addr), 32'(got), 32'd1);
        @(negedge clk);
        txns  = txn_count - t0;
        fills = fill_count - f0;
    endtask

    task automatic reset_two_cycles();
        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_cmem_valid_drop", 32'(bus.cmem_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        check("rst_code_err_clear", 32'(dbg_code_err), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          txns;
        int          fills;
        bit          hit;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] rdata;
    int          cycles, txns, fills;
    bit          m_valid, m_err, hit, found;
    logic [31:0] m_tag, line, slot;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;

        for (int i = 0; i < 256; i++) dict_m[i] = $urandom;
        dict_m[5] = 32'h0000_0013;
        for (int i = 0; i < 256; i++) dut.dict[i] = dict_m[i];

        mem[LAT_BASE + 0] = 32'h0000_1000;
        mem[32'h1000]     = 32'h8005_8005;
        mem[32'h1004]     = 32'h0093_0000;
        mem[32'h1008]     = 32'h8005_0010;
        mem[LAT_BASE + 4] = 32'h0000_2002;
        mem[32'h2000]     = 32'h8005_FFFF;
        mem[32'h2004]     = 32'h8005_8005;
        mem[32'h2008]     = 32'h0000_8005;
        mem[LAT_BASE + 8] = 32'h0000_3000;
        mem[32'h3000]     = 32'h1234_8005;
        mem[32'h3004]     = 32'h8005_8005;
        for (int l = 3; l < 10; l++) gen_line(32'(l));

        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_req_rdata", bus.req_rdata, 32'd0);
        check("reset_cmem_valid", 32'(bus.cmem_valid), 32'd0);
        check("reset_cmem_addr", bus.cmem_addr, 32'd0);
        check("reset_dbg_fill", 32'(dbg_fill), 32'd0);
        check("reset_dbg_code_err", 32'(dbg_code_err), 32'd0);
        resetn = 1'b1;

        // Directed table: first fill, hits, second line with offset start, refill.
        vecs[0] = '{32'h08, 32'h0010_0093, 4, 1, 1'b0};
        vecs[1] = '{32'h0C, 32'h0000_0013, 0, 0, 1'b1};
        vecs[2] = '{32'h00, 32'h0000_0013, 0, 0, 1'b1};
        vecs[3] = '{32'h04, 32'h0000_0013, 0, 0, 1'b1};
        vecs[4] = '{32'h10, 32'h0000_0013, 4, 1, 1'b0};
        vecs[5] = '{32'h1C, 32'h0000_0013, 0, 0, 1'b1};
        vecs[6] = '{32'h14, 32'h0000_0013, 0, 0, 1'b1};
        vecs[7] = '{32'h08, 32'h0010_0093, 4, 1, 1'b0};
        for (int v = 0; v < 8; v++) begin
            do_req(vecs[v].addr, rdata, cycles, txns, fills);
            check($sformatf("vec%0d_rdata", v), rdata, vecs[v].rdata);
            check($sformatf("vec%0d_txns", v), 32'(txns), 32'(vecs[v].txns));
            check($sformatf("vec%0d_fills", v), 32'(fills), 32'(vecs[v].fills));
            if (vecs[v].hit) check($sformatf("vec%0d_hit_latency", v), 32'(cycles), 32'd1);
        end
        check("no_code_err_yet", 32'(dbg_code_err), 32'd0);

        // Reserved code in slot 1 of line 2.
        do_req(32'h24, rdata, cycles, txns, fills);
        check("err_slot_rdata", rdata, 32'h0);
        check("err_txns", 32'(txns), 32'd3);
        check("err_flag_set", 32'(dbg_code_err), 32'd1);
        do_req(32'h20, rdata, cycles, txns, fills);
        check("err_line_hit_rdata", rdata, 32'h13);

        // Slow memory: request must hold steady while waiting.
        mem_delay = 5;
        stab_viol = 0;
        do_req(32'h08, rdata, cycles, txns, fills);
        check("slow_rdata", rdata, 32'h0010_0093);
        check("slow_txns", 32'(txns), 32'd4);
        check("slow_fills", 32'(fills), 32'd1);
        check("slow_stable", 32'(stab_viol), 32'd0);
        check("err_flag_sticky", 32'(dbg_code_err), 32'd1);

        // Reset while a LAT read is outstanding.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h10;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.cmem_valid) found = 1;
        end
        check("lat_request_seen", 32'(found), 32'd1);
        reset_two_cycles();
        mem_delay = 0;

        do_req(32'h10, rdata, cycles, txns, fills);
        check("post_rst_line1_txns", 32'(txns), 32'd4);

        // Reset while decoding line 0.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h08;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (dut.state_q == DECODE) found = 1;
        end
        check("decode_reached", 32'(found), 32'd1);
        reset_two_cycles();
        do_req(32'h08, rdata, cycles, txns, fills);
        check("refetch_rdata", rdata, 32'h0010_0093);
        check("refetch_txns", 32'(txns), 32'd4);
        check("refetch_fills", 32'(fills), 32'd1);

        // Reset from idle with a valid buffer must drop it.
        reset_two_cycles();
        do_req(32'h0C, rdata, cycles, txns, fills);
        check("idle_rst_rdata", rdata, 32'h13);
        check("idle_rst_txns", 32'(txns), 32'd4);

        // Randomized requests scored against the stream model.
        m_valid = 1;
        m_tag   = 32'd0;
        m_err   = 0;
        for (int it = 0; it < 40; it++) begin
            mem_delay = $urandom_range(0, 3);
            line      = 32'($urandom_range(0, 9));
            slot      = 32'($urandom_range(0, 3));
            model_line(line);
            hit = m_valid && (m_tag == line);
            stab_viol = 0;
            do_req((line << 4) | (slot << 2), rdata, cycles, txns, fills);
            check($sformatf("rand%0d_rdata", it), rdata, m_words[slot]);
            check($sformatf("rand%0d_txns", it), 32'(txns), hit ? 32'd0 : 32'(1 + m_fetches));
            check($sformatf("rand%0d_fills", it), 32'(fills), hit ? 32'd0 : 32'd1);
            check($sformatf("rand%0d_stable", it), 32'(stab_viol), 32'd0);
            if (hit) check($sformatf("rand%0d_hit_latency", it), 32'(cycles), 32'd1);
            if (!hit && m_err_line) m_err = 1;
            m_valid = 1;
            m_tag   = line;
            check($sformatf("rand%0d_code_err", it), 32'(dbg_code_err), 32'(m_err));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
